// File: rtl/pool_pkg.sv
// pool_pkg: window geometry and lane indexing shared with the max-pooling stage
package pool_pkg;
    localparam int POOL_DATA_W    = 22;
    localparam int POOL_WIN       = 4;
    localparam int POOL_WIN_ELEMS = POOL_WIN * POOL_WIN;
    function automatic int lane(input int r, input int c);
        return POOL_WIN * r + c;
    endfunction
endpackage

// File: rtl/pool_raster_counter.sv
// pool_raster_counter: raster col/row tracking with sof force and window/frame flags
// POOL_BUF_SOF_CHK_EN adds a sync_err flag for truncated or sof-less frames.
module pool_raster_counter #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic [CW-1:0] col,
    output logic [1:0]    row_lo,
    output logic          win_done,
`ifdef POOL_BUF_SOF_CHK_EN
    output logic          sync_err,
`endif
    output logic          frame_end
);
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q, row;
    logic          last_col, last_row;
    // sof re-labels the current pixel as (0,0) before any decision is made
    assign col       = in_sof ? '0 : col_q;
    assign row       = in_sof ? '0 : row_q;
    assign row_lo    = row[1:0];
    assign last_col  = col == CW'(IMG_W - 1);
    assign last_row  = row == RW'(IMG_H - 1);
    assign win_done  = in_valid & (col[1:0] == 2'd3) & (row[1:0] == 2'd3);
    assign frame_end = win_done & last_col & last_row;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            col_q <= last_col ? '0 : col + 1'b1;
            row_q <= last_col ? (last_row ? '0 : row + 1'b1) : row;
        end
`ifdef POOL_BUF_SOF_CHK_EN
    logic seen;
    logic at_origin;
    assign at_origin = (col_q == '0) && (row_q == '0);
    // the very first pixel after reset may start a frame without sof
    assign sync_err  = in_valid & (in_sof ? !at_origin : (seen & at_origin));
    always_ff @(posedge clk or posedge reset)
        if (reset)
            seen <= 1'b0;
        else if (in_valid)
            seen <= 1'b1;
`endif
endmodule

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: four-row pixel store emitting each non-overlapping 4x4 window in parallel
// POOL_BUF_SOF_CHK_EN enables the sticky frame-sync error output err.
module pool_window_buffer
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_sof,
    input  logic [DATA_W-1:0]                in_data,
    output logic [POOL_WIN_ELEMS*DATA_W-1:0] win_data,
    output logic                             win_valid,
    output logic                             frame_done,
    output logic                             err
);
    localparam int CW = $clog2(IMG_W);
    logic [DATA_W-1:0]                mem [POOL_WIN][IMG_W];
    logic [CW-1:0]                    col, cb;
    logic [1:0]                       row_lo;
    logic                             win_done, frame_end;
    logic [POOL_WIN_ELEMS*DATA_W-1:0] win_next;
`ifdef POOL_BUF_SOF_CHK_EN
    logic sync_err;
`endif
    pool_raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .col      (col),
        .row_lo   (row_lo),
        .win_done (win_done),
`ifdef POOL_BUF_SOF_CHK_EN
        .sync_err (sync_err),
`endif
        .frame_end(frame_end)
    );
    assign cb = {col[CW-1:2], 2'b00};
    // completing pixel is bypassed into lane 15 rather than read back from storage
    for (genvar r = 0; r < POOL_WIN; r++) begin : g_r
        for (genvar c = 0; c < POOL_WIN; c++) begin : g_c
            if (r == POOL_WIN - 1 && c == POOL_WIN - 1) begin : g_byp
                assign win_next[lane(r, c)*DATA_W +: DATA_W] = in_data;
            end else begin : g_mem
                assign win_next[lane(r, c)*DATA_W +: DATA_W] = mem[r][cb + CW'(c)];
            end
        end
    end
    always_ff @(posedge clk)
        if (in_valid)
            mem[row_lo][col] <= in_data;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            win_data   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_done;
            frame_done <= frame_end;
            if (win_done)
                win_data <= win_next;
        end
`ifdef POOL_BUF_SOF_CHK_EN
    always_ff @(posedge clk or posedge reset)
        if (reset)
            err <= 1'b0;
        else if (sync_err)
            err <= 1'b1;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: randomized frame stimulus checked against a full-frame reference model
module tb_pool_window_buffer;
    localparam int DW = 22;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int LW = 16 * DW;
    logic          clk = 0;
    logic          reset = 1;
    logic          in_valid = 0;
    logic          in_sof = 0;
    logic [DW-1:0] in_data = '0;
    logic [LW-1:0] win_data;
    logic          win_valid, frame_done, err;
    int            tests = 0, fails = 0;
    int            pr, pc, nwin, nfd, n0, f0;
    bit            seen, ev, ef, ee;
    logic [DW-1:0] img [H][W];
    logic [LW-1:0] ed, first_exp;

    pool_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .win_data  (win_data),
        .win_valid (win_valid),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pr = 0; pc = 0; seen = 0; ev = 0; ef = 0; ee = 0; ed = '0;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; in_sof = 0;
        #1;
        model_reset();
        check("rst_valid", LW'(win_valid), '0);
        check("rst_fdone", LW'(frame_done), '0);
        check("rst_data", win_data, '0);
        check("rst_err", LW'(err), '0);
        @(posedge clk); #1;
        reset = 0;
    endtask

    // one clock: drive, advance the frame-position model, then compare after the edge
    task automatic step(input logic v, input logic sof, input logic [DW-1:0] d);
        in_valid = v; in_sof = sof; in_data = d;
        ev = 0; ef = 0;
        if (v) begin
            if (sof) begin
`ifdef POOL_BUF_SOF_CHK_EN
                if (pr != 0 || pc != 0) ee = 1;
`endif
                pr = 0; pc = 0;
            end
`ifdef POOL_BUF_SOF_CHK_EN
            else if (pr == 0 && pc == 0 && seen) ee = 1;
`endif
            seen = 1;
            img[pr][pc] = d;
            if (pr % 4 == 3 && pc % 4 == 3) begin
                ev = 1;
                ef = (pr == H - 1) && (pc == W - 1);
                for (int k = 0; k < 16; k++)
                    ed[k*DW +: DW] = img[pr - 3 + k / 4][pc - 3 + k % 4];
            end
            pc++;
            if (pc == W) begin
                pc = 0; pr++;
                if (pr == H) pr = 0;
            end
        end
        @(posedge clk); #1;
        check("win_valid", LW'(win_valid), LW'(ev));
        check("frame_done", LW'(frame_done), LW'(ef));
        check("win_data", win_data, ed);
        check("err", LW'(err), LW'(ee));
        if (win_valid) nwin++;
        if (frame_done) nfd++;
    endtask

    task automatic frame(input int gap, input bit rnd);
        for (int i = 0; i < W * H; i++) begin
            while (gap != 0 && $urandom_range(99) < gap) step(0, 0, DW'($urandom));
            step(1, i == 0, rnd ? DW'($urandom) : DW'(i));
        end
    endtask

    initial begin
        nwin = 0; nfd = 0;
        for (int k = 0; k < 16; k++) first_exp[k*DW +: DW] = DW'((k / 4) * W + k % 4);
        do_reset();
        // single frame, pixel = row*8+col
        n0 = nwin; f0 = nfd;
        for (int i = 0; i < W * H; i++) begin
            step(1, i == 0, DW'(i));
            if (i == 27) check("first_win", win_data, first_exp);
        end
        check("win_cnt1", LW'(nwin - n0), LW'(4));
        check("fd_cnt1", LW'(nfd - f0), LW'(1));
        check("last_lane", LW'(win_data[15*DW +: DW]), LW'(63));
        // same frame with random idle gaps
        n0 = nwin; f0 = nfd;
        frame(30, 0);
        check("win_cnt_gap", LW'(nwin - n0), LW'(4));
        check("fd_cnt_gap", LW'(nfd - f0), LW'(1));
        // signed extremes at lanes 0 and 15
        for (int i = 0; i < W * H; i++) begin
            step(1, i == 0, i == 0 ? 22'h3FFFFF : i == 27 ? 22'h200000 : DW'($urandom));
            if (i == 27) begin
                check("lane0_neg1", LW'(win_data[0 +: DW]), LW'(22'h3FFFFF));
                check("lane15_min", LW'(win_data[15*DW +: DW]), LW'(22'h200000));
            end
        end
        // sof at (1,5) abandons the partial frame
        n0 = nwin;
        for (int i = 0; i < 13; i++) step(1, i == 0, DW'($urandom));
        check("no_spurious", LW'(nwin - n0), '0);
        n0 = nwin; f0 = nfd;
        frame(10, 1);
`ifdef POOL_BUF_SOF_CHK_EN
        check("err_sof", LW'(err), LW'(1));
`else
        check("err_sof", LW'(err), '0);
`endif
        check("win_cnt_sof", LW'(nwin - n0), LW'(4));
        check("fd_cnt_sof", LW'(nfd - f0), LW'(1));
        // reset after 20 pixels
        do_reset();
        for (int i = 0; i < 20; i++) step(1, i == 0, DW'($urandom));
        do_reset();
        for (int i = 0; i < W * H; i++) begin
            step(1, i == 0, DW'(i));
            if (i == 27) check("first_win_rst", win_data, first_exp);
        end
        // back-to-back frames
        do_reset();
        n0 = nwin; f0 = nfd;
        frame(0, 1);
        frame(0, 1);
        check("win_cnt_b2b", LW'(nwin - n0), LW'(8));
        check("fd_cnt_b2b", LW'(nfd - f0), LW'(2));
        check("err_b2b", LW'(err), '0);
        for (int i = 0; i < 3; i++) step(0, 0, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
